// File: rtl/mem_arbiter.sv
// Arbitrates the single main-memory port between I-cache refills and D-cache
// write-through / refill traffic, and routes each response back to its requester.
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int LINE_W       = 128,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              i_readmiss,
  input  logic [ADDR_W-1:0] i_address,
  output logic              i_readready,
  output logic [LINE_W-1:0] i_datareadmiss,
  input  logic              d_readmiss,
  input  logic              d_memwritethru,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [31:0]       d_datawrite,
  output logic              d_readready,
  output logic              d_writeready,
  output logic [LINE_W-1:0] d_datareadmiss,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [2:0] {IDLE, I_READ, D_WRITE, D_READ, RESP} state_t;

  localparam logic [3:0]        LIMIT     = 4'(STARVE_LIMIT);
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(15);

  state_t     state;
  logic [3:0] starve_cnt;
  logic       d_pend;
  logic       d_pick;

  assign d_pend = d_readmiss | d_memwritethru;
  // D wins unless it has already taken LIMIT grants while I was left waiting.
  assign d_pick = d_pend & ((starve_cnt < LIMIT) | ~i_readmiss);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state          <= IDLE;
      starve_cnt     <= '0;
      i_readready    <= 1'b0;
      d_readready    <= 1'b0;
      d_writeready   <= 1'b0;
      i_datareadmiss <= '0;
      d_datareadmiss <= '0;
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
    end else begin
      i_readready  <= 1'b0;
      d_readready  <= 1'b0;
      d_writeready <= 1'b0;
      case (state)
        IDLE: begin
          if (!i_readmiss) starve_cnt <= '0;
          if (d_pick) begin
            if (i_readmiss && (starve_cnt < LIMIT)) starve_cnt <= starve_cnt + 4'd1;
            mem_req   <= 1'b1;
            mem_wdata <= d_datawrite;
            // A write miss commits the word first; the refill follows from D_WRITE.
            if (d_memwritethru) begin
              state    <= D_WRITE;
              mem_we   <= 1'b1;
              mem_addr <= d_address & WORD_MASK;
            end else begin
              state    <= D_READ;
              mem_we   <= 1'b0;
              mem_addr <= d_address & LINE_MASK;
            end
          end else if (i_readmiss) begin
            starve_cnt <= '0;
            state      <= I_READ;
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= i_address & LINE_MASK;
          end
        end
        I_READ: begin
          if (mem_ack) begin
            i_datareadmiss <= mem_rdata;
            i_readready    <= 1'b1;
            mem_req        <= 1'b0;
            state          <= RESP;
          end
        end
        D_WRITE: begin
          if (mem_ack) begin
            d_writeready <= 1'b1;
            mem_we       <= 1'b0;
            if (d_readmiss) begin
              // Refill the same line straight away, keeping the port.
              state    <= D_READ;
              mem_addr <= mem_addr & LINE_MASK;
            end else begin
              mem_req <= 1'b0;
              state   <= RESP;
            end
          end
        end
        D_READ: begin
          if (mem_ack) begin
            d_datareadmiss <= mem_rdata;
            d_readready    <= 1'b1;
            mem_req        <= 1'b0;
            state          <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter: requester tasks queue expected
// memory transactions and responses; memory and response monitors pop and compare.
module tb_mem_arbiter;

  localparam int LIMIT = 4;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mtx_t;

  typedef struct packed {
    logic         wr;
    logic [127:0] line;
  } dresp_t;

  logic         Clk;
  logic         Rst;
  logic         i_readmiss;
  logic [31:0]  i_address;
  logic         i_readready;
  logic [127:0] i_datareadmiss;
  logic         d_readmiss;
  logic         d_memwritethru;
  logic [31:0]  d_address;
  logic [31:0]  d_datawrite;
  logic         d_readready;
  logic         d_writeready;
  logic [127:0] d_datareadmiss;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ack;

  int checks = 0;
  int errors = 0;

  mtx_t         exp_mi[$];
  mtx_t         exp_md[$];
  logic [127:0] exp_i[$];
  dresp_t       exp_d[$];
  byte          grant_log[$];

  logic mem_auto;
  int   fixed_delay;
  int   inject_req;
  logic i_at_edge;
  logic d_at_edge;
  int   d_kind;

  mem_arbiter #(.ADDR_W(32), .LINE_W(128), .STARVE_LIMIT(LIMIT)) dut (
    .Clk(Clk), .Rst(Rst),
    .i_readmiss(i_readmiss), .i_address(i_address),
    .i_readready(i_readready), .i_datareadmiss(i_datareadmiss),
    .d_readmiss(d_readmiss), .d_memwritethru(d_memwritethru),
    .d_address(d_address), .d_datawrite(d_datawrite),
    .d_readready(d_readready), .d_writeready(d_writeready),
    .d_datareadmiss(d_datareadmiss),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  always @(posedge Clk) begin
    i_at_edge <= i_readmiss;
    d_at_edge <= d_readmiss | d_memwritethru;
  end

  function automatic logic [127:0] line_of(input logic [31:0] a);
    return {a ^ 32'hA5A5_0000, ~a, a + 32'h1111_1111, {a[30:0], 1'b1}};
  endfunction

  function automatic mtx_t mk_tx(input logic we, input logic [31:0] a, input logic [31:0] wd);
    mtx_t t;
    t.we = we; t.addr = a; t.wdata = wd;
    return t;
  endfunction

  function automatic dresp_t mk_dr(input logic wr, input logic [127:0] l);
    dresp_t r;
    r.wr = wr; r.line = l;
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic i_request(input logic [31:0] a);
    logic seen;
    seen = 1'b0;
    i_address  = a;
    i_readmiss = 1'b1;
    exp_i.push_back(line_of(a & ~32'hF));
    exp_mi.push_back(mk_tx(1'b0, a & ~32'hF, 32'h0));
    for (int c = 0; c < 400 && !seen; c++) begin
      @(negedge Clk);
      if (i_readready) seen = 1'b1;
    end
    i_readmiss = 1'b0;
    check("i_ready_seen", 128'(seen), 128'(1));
  endtask

  task automatic d_request(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd);
    logic wdone, rdone;
    wdone = !wr;
    rdone = !rd;
    d_address      = a;
    d_datawrite    = wd;
    d_memwritethru = wr;
    d_readmiss     = rd;
    if (wr) begin
      exp_md.push_back(mk_tx(1'b1, a & ~32'h3, wd));
      exp_d.push_back(mk_dr(1'b1, '0));
    end
    if (rd) begin
      exp_md.push_back(mk_tx(1'b0, a & ~32'hF, 32'h0));
      exp_d.push_back(mk_dr(1'b0, line_of(a & ~32'hF)));
    end
    for (int c = 0; c < 400 && !(wdone && rdone); c++) begin
      @(negedge Clk);
      if (d_writeready) begin wdone = 1'b1; d_memwritethru = 1'b0; end
      if (d_readready)  begin rdone = 1'b1; d_readmiss = 1'b0; end
    end
    d_memwritethru = 1'b0;
    d_readmiss     = 1'b0;
    check("d_ready_seen", 128'(wdone && rdone), 128'(1));
  endtask

  // Memory: acks after 0..3 cycles, returns a line derived from the address,
  // and checks each new transaction against the requesters' queues and priority.
  initial begin : mem_model
    int   delay, model_cnt, inj_done;
    logic busy, prev_wr_ack, cont, is_d, exp_is_d;
    mtx_t t, g;
    mem_ack = 1'b0; mem_rdata = '0;
    busy = 1'b0; prev_wr_ack = 1'b0; model_cnt = 0; inj_done = 0; delay = 0;
    forever begin
      @(negedge Clk);
      mem_ack = 1'b0;
      cont = prev_wr_ack;
      prev_wr_ack = 1'b0;
      if (!Rst) begin
        busy = 1'b0;
        model_cnt = 0;
      end else if (inj_done != inject_req) begin
        inj_done++;
        mem_ack = 1'b1;
        mem_rdata = {4{32'hBAD0_BAD0}};
      end else if (mem_auto) begin
        if (mem_req && !busy) begin
          busy = 1'b1;
          delay = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
          g = mk_tx(mem_we, mem_addr, mem_we ? mem_wdata : 32'h0);
          if (cont) begin
            check("d_refill_queued", 128'(exp_md.size() != 0), 128'(1));
            if (exp_md.size() != 0) begin
              t = exp_md.pop_front();
              check("d_refill_after_write", 128'(g), 128'(t));
            end
          end else begin
            is_d = mem_we | mem_addr[20];
            exp_is_d = d_at_edge && (model_cnt < LIMIT || !i_at_edge);
            check("grant_choice", 128'(is_d), 128'(exp_is_d));
            grant_log.push_back(is_d ? 8'h44 : 8'h49);
            if (is_d) model_cnt = i_at_edge ? ((model_cnt < LIMIT) ? model_cnt + 1 : model_cnt) : 0;
            else model_cnt = 0;
            if (is_d) begin
              check("d_txn_queued", 128'(exp_md.size() != 0), 128'(1));
              if (exp_md.size() != 0) begin
                t = exp_md.pop_front();
                check("d_mem_txn", 128'(g), 128'(t));
              end
            end else begin
              check("i_txn_queued", 128'(exp_mi.size() != 0), 128'(1));
              if (exp_mi.size() != 0) begin
                t = exp_mi.pop_front();
                check("i_mem_txn", 128'(g), 128'(t));
              end
            end
          end
        end
        if (busy) begin
          check("mem_req_held", 128'(mem_req), 128'(1));
          if (!mem_req) busy = 1'b0;
          else if (delay == 0) begin
            mem_ack = 1'b1;
            mem_rdata = line_of(mem_addr);
            busy = 1'b0;
            prev_wr_ack = mem_we;
          end else delay--;
        end
      end
    end
  end

  initial begin : resp_monitor
    dresp_t       r;
    logic [127:0] l;
    forever begin
      @(negedge Clk);
      if (Rst && (i_readready || d_readready || d_writeready)) begin
        check("one_ready", 128'($countones({i_readready, d_readready, d_writeready})), 128'(1));
        if (i_readready) begin
          check("i_resp_expected", 128'(exp_i.size() != 0), 128'(1));
          if (exp_i.size() != 0) begin
            l = exp_i.pop_front();
            check("i_line", i_datareadmiss, l);
          end
        end
        if (d_writeready) begin
          check("d_wresp_expected", 128'(exp_d.size() != 0), 128'(1));
          if (exp_d.size() != 0) begin
            r = exp_d.pop_front();
            check("d_write_order", 128'(r.wr), 128'(1));
          end
        end
        if (d_readready) begin
          check("d_rresp_expected", 128'(exp_d.size() != 0), 128'(1));
          if (exp_d.size() != 0) begin
            r = exp_d.pop_front();
            check("d_read_order", 128'(r.wr), 128'(0));
            check("d_line", d_datareadmiss, r.line);
          end
        end
      end
    end
  end

  initial begin : main
    logic seen, req_seen;
    int   pulses;
    byte  gexp;
    i_readmiss = 1'b0; i_address = '0;
    d_readmiss = 1'b0; d_memwritethru = 1'b0; d_address = '0; d_datawrite = '0;
    mem_auto = 1'b1; fixed_delay = -1; inject_req = 0;
    Rst = 1'b1;
    #3 Rst = 1'b0;
    repeat (3) @(negedge Clk);
    check("rst_mem_req", 128'(mem_req), 128'(0));
    check("rst_mem_we", 128'(mem_we), 128'(0));
    check("rst_mem_addr", 128'(mem_addr), 128'(0));
    check("rst_mem_wdata", 128'(mem_wdata), 128'(0));
    check("rst_readys", 128'({i_readready, d_readready, d_writeready}), 128'(0));
    check("rst_i_line", i_datareadmiss, 128'(0));
    check("rst_d_line", d_datareadmiss, 128'(0));
    Rst = 1'b1;
    @(negedge Clk);

    // I refill with a two-cycle memory
    fixed_delay = 2;
    i_request(32'h0000_1234);
    check("i_line_held", i_datareadmiss, line_of(32'h0000_1230));
    fixed_delay = -1;
    @(negedge Clk);

    // Pure write-through, then a write miss
    d_request(1'b0, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF);
    @(negedge Clk);
    d_request(1'b1, 1'b1, 32'h0000_0084, 32'h1357_9BDF);
    repeat (2) @(negedge Clk);

    // D keeps re-requesting while I waits
    grant_log.delete();
    fork
      i_request(32'h0000_2000);
      for (int k = 0; k < 6; k++) d_request(1'b1, 1'b0, 32'h0010_0000 | (32'h100 * k), 32'h0);
    join
    for (int k = 0; k <= LIMIT; k++) begin
      gexp = (k < LIMIT) ? 8'h44 : 8'h49;
      check("starve_sequence", 128'((k < grant_log.size()) ? grant_log[k] : 8'h3F), 128'(gexp));
    end
    repeat (2) @(negedge Clk);

    // Same-edge I and D with no starvation history
    grant_log.delete();
    fork
      i_request(32'h0000_3330);
      d_request(1'b1, 1'b0, 32'h0010_4440, 32'h0);
    join
    check("same_edge_first", 128'((grant_log.size() > 0) ? grant_log[0] : 8'h3F), 128'(8'h44));
    check("same_edge_second", 128'((grant_log.size() > 1) ? grant_log[1] : 8'h3F), 128'(8'h49));
    repeat (2) @(negedge Clk);

    // Reset while a D refill is outstanding, then a stray ack
    mem_auto = 1'b0;
    d_address = 32'h0010_0500;
    d_readmiss = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge Clk);
      if (mem_req) seen = 1'b1;
    end
    check("abort_req_seen", 128'(seen), 128'(1));
    #2 Rst = 1'b0;
    #1;
    check("abort_mem_req", 128'(mem_req), 128'(0));
    check("abort_mem_we", 128'(mem_we), 128'(0));
    check("abort_mem_addr", 128'(mem_addr), 128'(0));
    check("abort_i_line", i_datareadmiss, 128'(0));
    check("abort_d_line", d_datareadmiss, 128'(0));
    d_readmiss = 1'b0;
    repeat (2) @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    inject_req++;
    pulses = 0;
    req_seen = 1'b0;
    repeat (6) begin
      @(negedge Clk);
      pulses += int'(i_readready) + int'(d_readready) + int'(d_writeready);
      if (mem_req) req_seen = 1'b1;
    end
    check("abort_no_ready", 128'(pulses), 128'(0));
    check("abort_no_req", 128'(req_seen), 128'(0));
    mem_auto = 1'b1;
    @(negedge Clk);

    // Random contention
    fork
      for (int k = 0; k < 25; k++) begin
        repeat ($urandom_range(0, 4)) @(negedge Clk);
        i_request($urandom & 32'h000F_FFFF);
      end
      for (int k = 0; k < 40; k++) begin
        repeat ($urandom_range(0, 4)) @(negedge Clk);
        d_kind = int'($urandom_range(0, 2));
        d_request(d_kind != 1, d_kind != 0, 32'h0010_0000 | ($urandom & 32'h000F_FFFF), $urandom);
      end
    join
    repeat (4) @(negedge Clk);
    check("drain_exp_i", 128'(exp_i.size()), 128'(0));
    check("drain_exp_d", 128'(exp_d.size()), 128'(0));
    check("drain_exp_mi", 128'(exp_mi.size()), 128'(0));
    check("drain_exp_md", 128'(exp_md.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
